// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SYNC/LEN/PAYLOAD/CHK frame parser with checksum-gated payload stream
// Optional good/bad frame counters: define UART_FRAME_PARSER_STATS_EN
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 86800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        rx_drop,
    output logic        busy
`ifdef UART_FRAME_PARSER_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {HUNT, GET_LEN, GET_PAY, GET_CHK, DRAIN} state_t;

    state_t        state;
    logic [PW-1:0] len_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [7:0]    sum;
    logic [TW-1:0] tmo_cnt;
    logic          handshake;
    logic          tmo_hit;
    logic [7:0]    buf_mem [2**PW];

    assign handshake = m_valid & m_ready;
    assign rd_next   = rd_ptr + PW'(1);
    assign busy      = (state != HUNT);
    // A byte arriving on the terminal-count cycle takes priority over the timeout
    assign tmo_hit   = (state == GET_LEN || state == GET_PAY || state == GET_CHK) &&
                       !rx_valid && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (state == GET_PAY && rx_valid)
            buf_mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            len_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sum       <= '0;
            tmo_cnt   <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            rx_drop   <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            rx_drop   <= 1'b0;

            if (rx_valid || state == HUNT || state == DRAIN)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (tmo_hit) begin
                frame_err <= 1'b1;
                err_code  <= 2'b11;
                state     <= HUNT;
            end else begin
                case (state)
                    HUNT: begin
                        if (rx_valid && rx_data == SYNC_BYTE)
                            state <= GET_LEN;
                    end
                    GET_LEN: begin
                        if (rx_valid) begin
                            sum    <= rx_data;
                            len_q  <= rx_data[PW-1:0];
                            wr_ptr <= '0;
                            if (rx_data > 8'(MAX_LEN)) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b10;
                                state     <= HUNT;
                            end else if (rx_data == 8'h00) begin
                                state <= GET_CHK;
                            end else begin
                                state <= GET_PAY;
                            end
                        end
                    end
                    GET_PAY: begin
                        if (rx_valid) begin
                            wr_ptr <= wr_ptr + PW'(1);
                            sum    <= sum + rx_data;
                            if (wr_ptr == len_q - PW'(1))
                                state <= GET_CHK;
                        end
                    end
                    GET_CHK: begin
                        if (rx_valid) begin
                            if (8'(sum + rx_data) != 8'h00) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b01;
                                state     <= HUNT;
                            end else if (len_q == '0) begin
                                frame_ok <= 1'b1;
                                state    <= HUNT;
                            end else begin
                                rd_ptr  <= '0;
                                m_data  <= buf_mem[0];
                                m_valid <= 1'b1;
                                m_last  <= (len_q == PW'(1));
                                state   <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        // Bytes arriving while the payload drains are discarded, never resynced on
                        if (rx_valid)
                            rx_drop <= 1'b1;
                        if (handshake) begin
                            if (m_last) begin
                                m_valid  <= 1'b0;
                                m_last   <= 1'b0;
                                frame_ok <= 1'b1;
                                state    <= HUNT;
                            end else begin
                                rd_ptr <= rd_next;
                                m_data <= buf_mem[rd_next];
                                m_last <= (rd_next == len_q - PW'(1));
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef UART_FRAME_PARSER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (frame_ok && good_cnt != 16'hFFFF)
                good_cnt <= good_cnt + 16'd1;
            if (frame_err && bad_cnt != 16'hFFFF)
                bad_cnt <= bad_cnt + 16'd1;
        end
    end
`endif

endmodule
